serial_stimulus_tx: RTL and testbench

- Buffered UART transmitter that generates the byte stream on the CPU's serial_in pin.
- In simulation it replaces the constant-high tie so benches can push BIOS commands and program bytes into the core. On the FPGA it also serves as the host-side loopback source.
- Accepts bytes over a ready/valid port into a small FIFO. Serialises them as 8N1 frames, LSB first, with no gap between back-to-back frames.

---
 rtl/serial_stimulus_tx.sv | 166 ++++++++++++++++
 tb/tb_serial_stimulus_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_stimulus_tx.sv
// Buffered 8N1 UART transmitter feeding the CPU's serial_in: ready/valid byte FIFO plus serialiser.
// Optional even-parity symbol between data and stop when SERIAL_TX_PARITY_EN is defined.
module serial_stimulus_tx #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic             push, pop, sym_end, fifo_nonempty;

  assign data_in_ready = (count_q != CNT_FULL);
  assign push          = data_in_valid && data_in_ready;
  assign fifo_nonempty = (count_q != '0);
  assign sym_end       = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (sym_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (sym_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (sym_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (sym_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so serial_out is a clean register.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_d];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  tx_d = ^shift_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  assign serial_out = tx_q;
  assign busy       = (state_q != IDLE) || fifo_nonempty;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_serial_stimulus_tx.sv
// Bench for serial_stimulus_tx: table of single-byte frames, directed multi-frame sequences,
// and a line decoder that pops expected bytes from a scoreboard queue.
module tb_serial_stimulus_tx;

  localparam int CLOCK_FREQ = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int FIFO_DEPTH = 4;
  localparam int SET        = 10;
`ifdef SERIAL_TX_PARITY_EN
  localparam int SYMS = 11;
`else
  localparam int SYMS = 10;
`endif
  localparam int FRAME = SYMS * SET;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;
  logic       busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[5];

  serial_stimulus_tx #(
    .CLOCK_FREQ(CLOCK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    data_in_valid = v;
    data_in       = d;
  endtask

  // Checks a whole frame cycle by cycle, starting at the negedge of its first start-bit cycle.
  task automatic check_frame(input logic [7:0] d, input logic p);
    int   sym;
    logic e;
    for (int t = 0; t < FRAME; t++) begin
      sym = t / SET;
      if (sym == 0)                     e = 1'b0;
      else if (sym <= 8)                e = d[sym-1];
      else if (SYMS == 11 && sym == 9)  e = p;
      else                              e = 1'b1;
      chk($sformatf("frame_%02h_t%0d", d, t), serial_out, e);
      chk("frame_busy", busy, 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", (n < budget), 1'b1);
  endtask

  // scoreboard: line decoder sampling mid-symbol
  logic       mon_active = 1'b0;
  int         mon_t      = 0;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (serial_out === 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
      end
    end else begin
      mon_t++;
      if (mon_t == SET / 2) begin
        chk("mon_start_bit", serial_out, 1'b0);
      end else if (mon_t > SET && mon_t < 9 * SET && (mon_t % SET) == SET / 2) begin
        mon_byte[mon_t / SET - 1] = serial_out;
`ifdef SERIAL_TX_PARITY_EN
      end else if (mon_t == 9 * SET + SET / 2) begin
        chk("mon_parity", serial_out, ^mon_byte);
`endif
      end else if (mon_t == (SYMS - 1) * SET + SET / 2) begin
        chk("mon_stop_bit", serial_out, 1'b1);
        if (exp_q.size() == 0) begin
          chk("mon_unexpected_frame", 1'b1, 1'b0);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("mon_byte", mon_byte, mon_exp);
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin
    int waited;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h80, 1'b1};
    vecs[3] = '{8'hFE, 1'b1};
    vecs[4] = '{8'h5A, 1'b0};

    rst           = 1'b1;
    data_in       = 8'h00;
    data_in_valid = 1'b0;

    // Reset held with valid asserted: nothing may be queued.
    #2;
    rst           = 1'b0;
    data_in_valid = 1'b1;
    data_in       = 8'h55;
    repeat (5) begin
      @(negedge clk);
      chk("rst_serial_out", serial_out, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fifo_count", fifo_count, 3'd0);
      chk("rst_ready", data_in_ready, 1'b1);
    end
    @(posedge clk);
    #1;
    rst           = 1'b1;
    data_in_valid = 1'b0;
    repeat (50) begin
      @(negedge clk);
      chk("post_rst_line_high", serial_out, 1'b1);
      chk("post_rst_busy", busy, 1'b0);
    end
    chk("post_rst_fifo_count", fifo_count, 3'd0);

    // Table-driven single-byte frames.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].data);
      @(negedge clk);
      chk("tbl_ready", data_in_ready, 1'b1);
      exp_q.push_back(vecs[i].data);
      drive(1'b0, 8'h00);
      @(negedge clk);
      chk("tbl_latency_line_still_high", serial_out, 1'b1);
      chk("tbl_count_after_push", fifo_count, 3'd1);
      chk("tbl_busy_after_push", busy, 1'b1);
      @(negedge clk);
      check_frame(vecs[i].data, vecs[i].par);
      chk("tbl_busy_falls", busy, 1'b0);
      chk("tbl_count_empty", fifo_count, 3'd0);
      chk("tbl_line_idle", serial_out, 1'b1);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: two frames with no idle gap.
    drive(1'b1, 8'h00);
    @(negedge clk);
    chk("b2b_ready0", data_in_ready, 1'b1);
    exp_q.push_back(8'h00);
    drive(1'b1, 8'hFF);
    @(negedge clk);
    chk("b2b_count_1", fifo_count, 3'd1);
    chk("b2b_ready1", data_in_ready, 1'b1);
    exp_q.push_back(8'hFF);
    drive(1'b0, 8'h00);
    @(negedge clk);
    chk("b2b_count_push_pop", fifo_count, 3'd1);
    check_frame(8'h00, 1'b0);
    check_frame(8'hFF, 1'b0);
    chk("b2b_count_0", fifo_count, 3'd0);
    chk("b2b_busy_falls", busy, 1'b0);
    repeat (3) @(negedge clk);

    // Full FIFO: 5 accepted immediately, the sixth waits for the first stop-bit pop.
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 8'(k));
      @(negedge clk);
      chk($sformatf("full_ready_%0d", k), data_in_ready, 1'b1);
      exp_q.push_back(8'(k));
    end
    drive(1'b1, 8'h06);
    @(negedge clk);
    chk("full_count_4", fifo_count, 3'd4);
    chk("full_ready_low", data_in_ready, 1'b0);
    waited = 0;
    while (data_in_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("full_wait_cycles", waited, FRAME - 3);
    chk("full_count_before_6th", fifo_count, 3'd3);
    exp_q.push_back(8'h06);
    drive(1'b0, 8'h00);
    @(negedge clk);
    chk("full_count_after_6th", fifo_count, 3'd4);
    wait_idle(FRAME * 8);
    chk("full_all_sent", exp_q.size(), 0);

    // Mid-frame asynchronous reset with a second byte still buffered.
    drive(1'b1, 8'h3C);
    @(negedge clk);
    exp_q.push_back(8'h3C);
    drive(1'b1, 8'h5A);
    @(negedge clk);
    exp_q.push_back(8'h5A);
    drive(1'b0, 8'h00);
    @(negedge clk);
    chk("mid_start_low", serial_out, 1'b0);
    repeat (35) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_line_high", serial_out, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", fifo_count, 3'd0);
    chk("mid_rst_ready", data_in_ready, 1'b1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (150) begin
      @(negedge clk);
      chk("mid_post_line_high", serial_out, 1'b1);
      chk("mid_post_busy", busy, 1'b0);
    end
    chk("mid_post_count", fifo_count, 3'd0);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
